aes_key_schedule: RTL and testbench

//  Sequential, parametrised AES key schedule for AES-128/192/256 (FIPS-197).

---
 rtl/aes_pkg.sv | 46 ++++
 rtl/aes_sbox.sv | 16 +
 rtl/aes_key_schedule.sv | 240 ++++++++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared AES types and helpers for the key schedule.
//   byte_t  : one AES byte
//   word_t  : 4 bytes, index 0 is the first byte of the word
//   block_t : 16 bytes, index 4j+k is byte k of word j
//   ks_state_t : key schedule controller states
//   SBOX    : forward AES S-box table, indexed by input byte
//   xtime() : multiply by x in GF(2^8) with 0x1b reduction
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0] byte_t;
    typedef byte_t [3:0] word_t;
    typedef byte_t [15:0] block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        DRAIN = 2'd2
    } ks_state_t;

    localparam byte_t SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
//   Combinational forward AES S-box lookup.
//   sub_i : input byte
//   sub_o : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] sub_i,
    output logic [7:0] sub_o
);

    assign sub_o = SBOX[sub_i];

endmodule

// File: rtl/aes_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_key_schedule
//   Sequential AES-128/192/256 key expansion. A cipher key is loaded on a
//   start handshake, one 32-bit schedule word is produced per clock through a
//   single SubWord path, and round keys 0..NR are streamed out in order on a
//   valid/ready handshake.
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous, active-high; clears all state
//     start      request a new expansion
//     start_rdy  high only while idle; accept = start && start_rdy
//     key        cipher key, byte 0 first, sampled on accept
//     rk         round key, byte 4j+k is byte k of word j
//     rk_round   round index of rk (0..NR)
//     rk_valid   rk/rk_round hold a valid round key
//     rk_ready   consumer accepts rk when rk_valid && rk_ready
//     rk_last    rk_valid && rk_round == NR
//     rd_idx     stored round key to read back (store build only)
//     rd_key     registered read data (store build only, else 0)
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high; while valid is high and ready is low, rk and rk_round hold.
//
//   Build option ROUNDKEY_STORE_EN: keeps an (NR+1)-entry copy of every round
//   key accepted by the consumer so the decrypt path can replay them.
// ---------------------------------------------------------------------------
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       start_rdy,
    input  logic [KEY_BITS/8-1:0][7:0] key,
    output logic [15:0][7:0]           rk,
    output logic [3:0]                 rk_round,
    output logic                       rk_valid,
    input  logic                       rk_ready,
    output logic                       rk_last,
    input  logic [3:0]                 rd_idx,
    output logic [15:0][7:0]           rd_key
);

    localparam int NK    = KEY_BITS / 32;
    localparam int NR    = NK + 6;
    localparam int NW    = 4 * (NR + 1);
    localparam int CNT_W = 6;
    localparam int KW    = 3;

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
    end

    ks_state_t          state_q;
    logic               rdy_q;
    word_t [NK-1:0]     win_q;       // win_q[0] = w[i-NK], win_q[NK-1] = w[i-1]
    logic [CNT_W-1:0]   cnt_q;       // index i of the next word to generate
    logic [KW-1:0]      kidx_q;      // i mod NK, kept as a wrapping counter
    byte_t              rcon_q;
    word_t [3:0]        acc_q;
    logic [2:0]         acc_cnt_q;   // 0..4 words held; 4 means a full group
    logic [3:0]         grp_q;       // round index of the group being collected
    block_t             rk_q;
    logic [3:0]         rk_round_q;
    logic               rk_valid_q;

    logic  accept;
    logic  drain;
    logic  acc_full;
    logic  xfer;
    logic  gen;
    logic  first_pass;
    logic  last_word;
    logic  round_done;
    word_t oldest;
    word_t newest;
    word_t rot_word;
    word_t sub_in;
    word_t sub_out;
    word_t word_d;

    assign accept     = start && rdy_q;
    assign drain      = rk_valid_q && rk_ready;
    assign acc_full   = acc_cnt_q[2];
    // A full group moves out when the output register is empty or being
    // emptied this very cycle.
    assign xfer       = acc_full && (!rk_valid_q || rk_ready);
    // Generation stalls only when the accumulator cannot make room.
    assign gen        = (state_q == GEN) && (!acc_full || xfer);
    assign first_pass = (cnt_q < CNT_W'(NK));
    assign last_word  = (cnt_q == CNT_W'(NW - 1));
    assign round_done = drain && (rk_round_q == 4'(NR));

    assign oldest   = win_q[0];
    assign newest   = win_q[NK-1];
    // RotWord: byte k of the result is byte k+1 of the input.
    assign rot_word = {newest[0], newest[3], newest[2], newest[1]};
    assign sub_in   = (kidx_q == '0) ? rot_word : newest;

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .sub_i (sub_in[b]),
            .sub_o (sub_out[b])
        );
    end

    // During the first NK words the window holds the key and rotates, so its
    // oldest entry is exactly key word i.
    always_comb begin
        word_d = oldest;
        if (!first_pass) begin
            if (kidx_q == '0) begin
                word_d    = oldest ^ sub_out;
                word_d[0] = word_d[0] ^ rcon_q;
            end else if (NK == 8 && kidx_q == KW'(4)) begin
                word_d = oldest ^ sub_out;
            end else begin
                word_d = oldest ^ newest;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rdy_q      <= 1'b1;
            win_q      <= '0;
            cnt_q      <= '0;
            kidx_q     <= '0;
            rcon_q     <= 8'h01;
            acc_q      <= '0;
            acc_cnt_q  <= '0;
            grp_q      <= '0;
            rk_q       <= '0;
            rk_round_q <= '0;
            rk_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= GEN;
                        rdy_q     <= 1'b0;
                        win_q     <= key;
                        cnt_q     <= '0;
                        kidx_q    <= '0;
                        rcon_q    <= 8'h01;
                        acc_cnt_q <= '0;
                        grp_q     <= '0;
                    end
                end
                GEN: begin
                    if (gen && last_word) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (round_done) begin
                        state_q <= IDLE;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                end
            endcase

            if (gen) begin
                win_q  <= {word_d, win_q[NK-1:1]};
                cnt_q  <= cnt_q + CNT_W'(1);
                kidx_q <= (kidx_q == KW'(NK - 1)) ? '0 : kidx_q + KW'(1);
                if (!first_pass && kidx_q == '0) begin
                    rcon_q <= xtime(rcon_q);
                end
            end

            // A word generated in the same cycle as a transfer starts the
            // next group in slot 0.
            if (gen) begin
                if (xfer) begin
                    acc_q[0]  <= word_d;
                    acc_cnt_q <= 3'd1;
                end else begin
                    acc_q[acc_cnt_q[1:0]] <= word_d;
                    acc_cnt_q             <= acc_cnt_q + 3'd1;
                end
            end else if (xfer) begin
                acc_cnt_q <= '0;
            end

            if (xfer) begin
                rk_q       <= acc_q;
                rk_round_q <= grp_q;
                grp_q      <= grp_q + 4'd1;
                rk_valid_q <= 1'b1;
            end else if (drain) begin
                rk_valid_q <= 1'b0;
            end
        end
    end

    assign start_rdy = rdy_q;
    assign rk        = rk_q;
    assign rk_round  = rk_round_q;
    assign rk_valid  = rk_valid_q;
    assign rk_last   = rk_valid_q && (rk_round_q == 4'(NR));

`ifdef ROUNDKEY_STORE_EN
    block_t store_q [0:NR];
    block_t rd_key_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r <= NR; r++) begin
                store_q[r] <= '0;
            end
            rd_key_q <= '0;
        end else begin
            if (accept) begin
                for (int r = 0; r <= NR; r++) begin
                    store_q[r] <= '0;
                end
            end else if (drain) begin
                store_q[rk_round_q] <= rk_q;
            end
            rd_key_q <= (rd_idx <= 4'(NR)) ? store_q[rd_idx] : '0;
        end
    end

    assign rd_key = rd_key_q;
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^rd_idx;
    assign rd_key        = '0;
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
module tb_aes_key_schedule;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       sel = 2'd0;
  logic [2:0]       start_v = '0;
  logic             rk_ready = 1'b1;
  logic [31:0][7:0] key_bus = '0;
  logic [3:0]       rd_idx = '0;

  logic [2:0]       start_rdy_a;
  logic [2:0]       rk_valid_a;
  logic [2:0]       rk_last_a;
  logic [15:0][7:0] rk_a [3];
  logic [3:0]       rk_round_a [3];
  logic [15:0][7:0] rd_key_a [3];

  logic             start_rdy_s;
  logic             rk_valid_s;
  logic             rk_last_s;
  logic [15:0][7:0] rk_s;
  logic [3:0]       rk_round_s;
  logic [15:0][7:0] rd_key_s;

  aes_key_schedule #(.KEY_BITS(128)) u_ks128 (
    .clk(clk), .reset(reset), .start(start_v[0]), .start_rdy(start_rdy_a[0]),
    .key(key_bus[15:0]), .rk(rk_a[0]), .rk_round(rk_round_a[0]), .rk_valid(rk_valid_a[0]),
    .rk_ready(rk_ready), .rk_last(rk_last_a[0]), .rd_idx(rd_idx), .rd_key(rd_key_a[0])
  );

  aes_key_schedule #(.KEY_BITS(192)) u_ks192 (
    .clk(clk), .reset(reset), .start(start_v[1]), .start_rdy(start_rdy_a[1]),
    .key(key_bus[23:0]), .rk(rk_a[1]), .rk_round(rk_round_a[1]), .rk_valid(rk_valid_a[1]),
    .rk_ready(rk_ready), .rk_last(rk_last_a[1]), .rd_idx(rd_idx), .rd_key(rd_key_a[1])
  );

  aes_key_schedule #(.KEY_BITS(256)) u_ks256 (
    .clk(clk), .reset(reset), .start(start_v[2]), .start_rdy(start_rdy_a[2]),
    .key(key_bus[31:0]), .rk(rk_a[2]), .rk_round(rk_round_a[2]), .rk_valid(rk_valid_a[2]),
    .rk_ready(rk_ready), .rk_last(rk_last_a[2]), .rd_idx(rd_idx), .rd_key(rd_key_a[2])
  );

  always_comb begin
    start_rdy_s = start_rdy_a[sel];
    rk_valid_s  = rk_valid_a[sel];
    rk_last_s   = rk_last_a[sel];
    rk_s        = rk_a[sel];
    rk_round_s  = rk_round_a[sel];
    rd_key_s    = rd_key_a[sel];
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0]   sbox_tab [256];
  logic [31:0]  ref_w [60];
  logic [127:0] exp_q [$];
  logic [127:0] got_rk [15];
  int           valid_at [15];
  int           hs_total;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] r;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      r = inv;
      r = r ^ rotl1(inv) ^ rotl1(rotl1(inv)) ^ rotl1(rotl1(rotl1(inv))) ^ rotl1(rotl1(rotl1(rotl1(inv))));
      sbox_tab[v] = r ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // FIPS-197 key expansion on big-endian words (first key byte in bits 31:24).
  task automatic build_ref(input int nk, input logic [31:0][7:0] kb);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        ref_w[i] = {kb[4*i], kb[4*i+1], kb[4*i+2], kb[4*i+3]};
      end else begin
        t = ref_w[i-1];
        if (i % nk == 0) begin
          t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk == 8 && i % nk == 4) begin
          t = sub_word(t);
        end
        ref_w[i] = ref_w[i-nk] ^ t;
      end
    end
  endtask

  function automatic logic [127:0] blk_be(input logic [15:0][7:0] b);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r;
  endfunction

  task automatic check_reset_values(input string tag);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if (start_rdy_s !== 1'b1 || rk_valid_s !== 1'b0 || rk_last_s !== 1'b0 ||
          rk_s !== '0 || rk_round_s !== 4'd0 || rd_key_s !== '0) begin
        errors++;
        $display("FAIL %s inst=%0d: rdy=%b valid=%b last=%b rk=%h round=%0d rd_key=%h, required 1 0 0 0 0 0",
                 tag, s, start_rdy_s, rk_valid_s, rk_last_s, rk_s, rk_round_s, rd_key_s);
      end
    end
  endtask

  // Runs one expansion on instance s; rounds are checked on every handshake.
  task automatic run_expansion(input int s, input logic [255:0] key_hex, input bit rand_ready,
                               input bit poke_start, input int abort_round);
    int nk, nr, t, hs, guard, nbytes;
    bit done, stalled, aborted;
    logic [15:0][7:0] held_rk;
    logic [3:0] held_round;
    logic [127:0] got, exp;
    nk = 4 + 2 * s;
    nr = nk + 6;
    nbytes = 4 * nk;
    sel = 2'(s);
    key_bus = '0;
    for (int i = 0; i < nbytes; i++) key_bus[i] = key_hex[8*(nbytes-1-i) +: 8];
    build_ref(nk, key_bus);
    exp_q.delete();
    for (int r = 0; r <= nr; r++) exp_q.push_back({ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]});
    for (int r = 0; r < 15; r++) begin valid_at[r] = -1; got_rk[r] = '0; end
    rk_ready = 1'b1;
    @(negedge clk);
    guard = 0;
    while (!start_rdy_s && guard < 200) begin @(negedge clk); guard++; end
    checks++;
    if (!start_rdy_s) begin
      errors++;
      $display("FAIL start_rdy_wait inst=%0d: start_rdy=%b, required 1", s, start_rdy_s);
    end
    start_v[s] = 1'b1;
    @(posedge clk);
    #1 start_v[s] = 1'b0;
    // Key changes after accept must not matter.
    for (int i = 0; i < 32; i++) key_bus[i] = 8'($urandom_range(0, 255));
    t = 0; hs = 0; done = 0; stalled = 0; aborted = 0;
    held_rk = '0; held_round = '0;
    while (!done && !aborted && t < 1000) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (rk_valid_s !== 1'b1 || rk_s !== held_rk || rk_round_s !== held_round) begin
          errors++;
          $display("FAIL hold t=%0d: valid=%b rk=%h round=%0d, required 1 %h %0d",
                   t, rk_valid_s, rk_s, rk_round_s, held_rk, held_round);
        end
      end
      if (poke_start && t == 20) begin
        checks++;
        if (start_rdy_s !== 1'b0) begin
          errors++;
          $display("FAIL busy_rdy: start_rdy=%b, required 0", start_rdy_s);
        end
        start_v[s] = 1'b1;
      end else begin
        start_v[s] = 1'b0;
      end
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rk_valid_s && valid_at[rk_round_s] < 0) valid_at[rk_round_s] = t;
      if (abort_round >= 0 && rk_valid_s && int'(rk_round_s) == abort_round) begin
        reset = 1'b1;
        #1;
        check_reset_values("async_abort");
        sel = 2'(s);
        aborted = 1;
      end else if (rk_valid_s && rk_ready) begin
        got = blk_be(rk_s);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_key round=%0d: rk=%h, required no handshake", rk_round_s, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp || rk_round_s !== 4'(hs) || rk_last_s !== (hs == nr)) begin
            errors++;
            $display("FAIL round_key hs=%0d: rk=%h round=%0d last=%b, required %h %0d %b",
                     hs, got, rk_round_s, rk_last_s, exp, hs, (hs == nr));
          end
        end
        if (hs < 15) got_rk[hs] = got;
        hs++;
        if (int'(rk_round_s) == nr) done = 1;
        stalled = 0;
      end else if (rk_valid_s) begin
        stalled = 1;
        held_rk = rk_s;
        held_round = rk_round_s;
      end else begin
        stalled = 0;
      end
      t++;
    end
    start_v[s] = 1'b0;
    hs_total = hs;
    if (aborted) begin
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    checks++;
    if (!done || hs != nr + 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL completion inst=%0d: done=%b handshakes=%0d left=%0d, required 1 %0d 0",
               s, done, hs, exp_q.size(), nr + 1);
    end
    rk_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (rk_valid_s !== 1'b0 || start_rdy_s !== 1'b1) begin
        errors++;
        $display("FAIL idle_after inst=%0d c=%0d: valid=%b rdy=%b, required 0 1", s, c, rk_valid_s, start_rdy_s);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("after_release");
  endtask

  task automatic test_aes128_vector();
    bit lat_ok;
    run_expansion(0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0, -1);
    checks++;
    if (got_rk[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      errors++; $display("FAIL aes128_r0: %h, required 2b7e151628aed2a6abf7158809cf4f3c", got_rk[0]);
    end
    checks++;
    if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      errors++; $display("FAIL aes128_r1: %h, required a0fafe1788542cb123a339392a6c7605", got_rk[1]);
    end
    checks++;
    if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++; $display("FAIL aes128_r10: %h, required d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
    end
    checks++;
    if (valid_at[10] != 45) begin
      errors++; $display("FAIL aes128_r10_latency: valid after edge E0+%0d, required E0+45", valid_at[10]);
    end
    lat_ok = 1;
    for (int r = 0; r <= 10; r++) if (valid_at[r] != 4 * r + 5) lat_ok = 0;
    checks++;
    if (!lat_ok) begin
      errors++; $display("FAIL aes128_cadence: r0 at %0d r1 at %0d r5 at %0d, required 5 9 25",
                         valid_at[0], valid_at[1], valid_at[5]);
    end
  endtask

  task automatic test_store();
    logic [127:0] rd;
    sel = 2'd0;
    @(negedge clk);
    rd_idx = 4'd10;
    @(negedge clk);
    rd = blk_be(rd_key_s);
    checks++;
`ifdef ROUNDKEY_STORE_EN
    if (rd !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++; $display("FAIL store_idx10: %h, required d014f9a8c9ee2589e13f0cc8b6630ca6", rd);
    end
`else
    if (rd !== '0) begin
      errors++; $display("FAIL store_off_idx10: %h, required 0", rd);
    end
`endif
    rd_idx = 4'd0;
    @(negedge clk);
    rd = blk_be(rd_key_s);
    checks++;
`ifdef ROUNDKEY_STORE_EN
    if (rd !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      errors++; $display("FAIL store_idx0: %h, required 2b7e151628aed2a6abf7158809cf4f3c", rd);
    end
`else
    if (rd !== '0) begin
      errors++; $display("FAIL store_off_idx0: %h, required 0", rd);
    end
`endif
    rd_idx = 4'd15;
    @(negedge clk);
    checks++;
    if (rd_key_s !== '0) begin
      errors++; $display("FAIL store_idx15: %h, required 0", blk_be(rd_key_s));
    end
    rd_idx = 4'd0;
  endtask

  task automatic test_aes192_vector();
    run_expansion(1, 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 1'b0, 1'b0, -1);
    checks++;
    if (got_rk[12] !== 128'he98ba06f448c773c8ecc720401002202) begin
      errors++; $display("FAIL aes192_r12: %h, required e98ba06f448c773c8ecc720401002202", got_rk[12]);
    end
  endtask

  task automatic test_aes256_vector();
    run_expansion(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b0, 1'b0, -1);
    checks++;
    if (got_rk[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
      errors++; $display("FAIL aes256_r14: %h, required fe4890d1e6188d0b046df344706c631e", got_rk[14]);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] k;
    run_expansion(0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 1'b1, -1);
    checks++;
    if (hs_total != 11) begin
      errors++; $display("FAIL bp_handshakes: %0d, required 11", hs_total);
    end
    for (int s = 0; s < 3; s++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      run_expansion(s, k, 1'b1, 1'b0, -1);
    end
  endtask

  task automatic test_reset_mid_gen();
    run_expansion(0, 256'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b0, 3);
    run_expansion(0, 256'h0, 1'b0, 1'b0, -1);
    checks++;
    if (got_rk[1] !== 128'h62636363626363636263636362636363) begin
      errors++; $display("FAIL zero_key_r1: %h, required 62636363626363636263636362636363", got_rk[1]);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_aes128_vector();
    test_store();
    test_aes192_vector();
    test_aes256_vector();
    test_backpressure();
    test_reset_mid_gen();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
